// File: rtl/param_counter_address_register.sv
// Up/down address register with synchronized edge-triggered inc/dec requests and tristate Addr/Bus drivers.
// Optional feature macro CAR_AUTOINC_EN: the rising edge of a_addr_n acts as an extra up request.
module param_counter_address_register #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  input  logic             load_n,
  input  logic             a_addr_n,
  input  logic             a_bus_n,
  inout  wire  [WIDTH-1:0] Addr,
  inout  wire  [WIDTH-1:0] Bus,
  output logic             at_zero,
  output logic             at_max,
  output logic             carry,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STEP_VAL = WIDTH'(STEP);

  logic             inc_s1_q, inc_s2_q, inc_s3_q;
  logic             inc_s1_d, inc_s2_d, inc_s3_d;
  logic             dec_s1_q, dec_s2_q, dec_s3_q;
  logic             dec_s1_d, dec_s2_d, dec_s3_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             up_edge_c, dn_edge_c, auto_up_c;
  logic [WIDTH:0]   sum_c;
  logic             over_c, under_c;

`ifdef CAR_AUTOINC_EN
  // a_addr_n is sampled once plus a history flop; its rising edge is the end of an address cycle
  logic aa_s1_q, aa_s1_d, aa_s2_q, aa_s2_d;

  always_comb begin
    aa_s1_d   = a_addr_n;
    aa_s2_d   = aa_s1_q;
    auto_up_c = aa_s1_q & ~aa_s2_q;
  end

  always_ff @(posedge clock) begin
    aa_s1_q <= aa_s1_d;
    aa_s2_q <= aa_s2_d;
  end
`else
  assign auto_up_c = 1'b0;
`endif

  // Next-state: synchronizer shift, edge detect, then load/step priority chain
  always_comb begin
    inc_s1_d  = inc;
    inc_s2_d  = inc_s1_q;
    inc_s3_d  = inc_s2_q;
    dec_s1_d  = dec;
    dec_s2_d  = dec_s1_q;
    dec_s3_d  = dec_s2_q;
    count_d   = count_q;
    carry_d   = 1'b0;
    borrow_d  = 1'b0;
    up_edge_c = (inc_s2_q & ~inc_s3_q) | auto_up_c;
    dn_edge_c = dec_s2_q & ~dec_s3_q;
    sum_c     = {1'b0, count_q} + {1'b0, STEP_VAL};
    over_c    = sum_c[WIDTH];
    under_c   = (count_q < STEP_VAL);

    if (!load_n) begin
      count_d = Bus;
    end else if (up_edge_c && dn_edge_c) begin
      count_d = count_q;
    end else if (up_edge_c) begin
      carry_d = over_c;
      count_d = (over_c && (SATURATE != 0)) ? MAX_VAL : sum_c[WIDTH-1:0];
    end else if (dn_edge_c) begin
      borrow_d = under_c;
      count_d  = (under_c && (SATURATE != 0)) ? {WIDTH{1'b0}} : (count_q - STEP_VAL);
    end
  end

  // Synchronizer flops keep sampling through clear so a held level never becomes a late edge
  always_ff @(posedge clock) begin
    inc_s1_q <= inc_s1_d;
    inc_s2_q <= inc_s2_d;
    inc_s3_q <= inc_s3_d;
    dec_s1_q <= dec_s1_d;
    dec_s2_q <= dec_s2_d;
    dec_s3_q <= dec_s3_d;
    if (clear) begin
      count_q  <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign carry   = carry_q;
  assign borrow  = borrow_q;
  assign at_zero = (count_q == {WIDTH{1'b0}});
  assign at_max  = (count_q == MAX_VAL);

  // Loading while a_bus_n=0 reads back our own drive, so the count holds
  assign Addr = a_addr_n ? {WIDTH{1'bz}} : count_q;
  assign Bus  = a_bus_n  ? {WIDTH{1'bz}} : count_q;

endmodule
